// File: rtl/rom_read_arbiter_if.sv
// rtl/rom_read_arbiter_if.sv - requester-side request/response bundle of the ROM read arbiter
interface rom_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - shares one fixed-latency ROM read port between NUM_REQ requesters
// Optional ROM_ARB_FIXED_PRIO_EN: fixed lowest-index priority instead of round-robin.
module rom_read_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk_rom_clk,
    input  logic                rst_rom_reset,
    rom_read_arbiter_if.slave   req_bus,
    input  logic                pause_req,
    output logic                pause_ack,
    output logic [ADDR_W-1:0]   rom_address,
    output logic                rom_chipselect,
    output logic                rom_clken,
    output logic                rom_write,
    output logic [DATA_W-1:0]   rom_writedata,
    output logic [DATA_W/8-1:0] rom_byteenable,
    output logic                rom_debugaccess,
    input  logic [DATA_W-1:0]   rom_readdata
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   grant_any;
    logic [ID_W-1:0]        grant_idx;
    logic                   accept;
    logic                   in_flight_zero;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [ID_W-1:0]        tag_id [READ_LATENCY];

`ifdef ROM_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_bus.req_valid[i]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    // Scan from farthest to nearest so the requester closest after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_any = 1'b1;
                grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk_rom_clk) begin
        if (rst_rom_reset) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr <= grant_idx;
        end
    end
`endif

    assign accept = grant_any && (state == RUN) && !pause_req && !rst_rom_reset;

    always_comb begin
        req_bus.req_ready = '0;
        if (accept) begin
            req_bus.req_ready[grant_idx] = 1'b1;
        end
    end

    assign rom_chipselect  = accept;
    assign rom_address     = accept ? req_bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W] : '0;
    assign rom_clken       = ~rst_rom_reset;
    assign rom_write       = 1'b0;
    assign rom_writedata   = '0;
    assign rom_byteenable  = '1;
    assign rom_debugaccess = 1'b0;

    // Tag pipeline: the last stage lines up with rom_readdata for the same read.
    always_ff @(posedge clk_rom_clk) begin
        if (rst_rom_reset) begin
            tag_valid <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= accept;
            tag_id[0]    <= grant_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    assign in_flight_zero = ~|tag_valid;

    always_ff @(posedge clk_rom_clk) begin
        if (rst_rom_reset) begin
            req_bus.rsp_valid <= '0;
            req_bus.rsp_data  <= '0;
        end else begin
            req_bus.rsp_valid <= tag_valid[READ_LATENCY-1]
                               ? (NUM_REQ'(1) << tag_id[READ_LATENCY-1]) : '0;
            if (tag_valid[READ_LATENCY-1]) begin
                req_bus.rsp_data <= rom_readdata;
            end
        end
    end

    always_ff @(posedge clk_rom_clk) begin
        if (rst_rom_reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pause_ack = 1'b0;
        case (state)
            RUN:     if (pause_req) state_nxt = DRAIN;
            DRAIN: begin
                if (!pause_req)          state_nxt = RUN;
                else if (in_flight_zero) state_nxt = PAUSED;
            end
            PAUSED: begin
                pause_ack = 1'b1;
                if (!pause_req) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end
endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - scoreboard bench running READ_LATENCY 1 and 2 instances side by side
module tb_rom_read_arbiter;
    localparam int NR = 3;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*AW-1:0] req_addr;
    logic             pause_req;
    int               cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t sb [2][$];
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [1:0][NR-1:0]   o_ready;
    logic [1:0][NR-1:0]   o_rsp_valid;
    logic [1:0][DW-1:0]   o_rsp_data;
    logic [1:0]           o_ack, o_cs, o_clken, o_wr, o_dbg;
    logic [1:0][AW-1:0]   o_addr;
    logic [1:0][DW-1:0]   o_wdata;
    logic [1:0][DW/8-1:0] o_be;

    function automatic logic [DW-1:0] rom_fn(logic [AW-1:0] a);
        return 32'hDEAD0000 | {22'd0, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g + 1;
        rom_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [AW-1:0]   rom_address;
        logic            rom_chipselect, rom_clken, rom_write, rom_debugaccess, pause_ack;
        logic [DW-1:0]   rom_writedata, rom_readdata;
        logic [DW/8-1:0] rom_byteenable;
        logic [DW-1:0]   rd_pipe [LAT];

        assign bus.req_valid = req_valid;
        assign bus.req_addr  = req_addr;

        rom_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
            .clk_rom_clk    (clk),
            .rst_rom_reset  (rst),
            .req_bus        (bus),
            .pause_req      (pause_req),
            .pause_ack      (pause_ack),
            .rom_address    (rom_address),
            .rom_chipselect (rom_chipselect),
            .rom_clken      (rom_clken),
            .rom_write      (rom_write),
            .rom_writedata  (rom_writedata),
            .rom_byteenable (rom_byteenable),
            .rom_debugaccess(rom_debugaccess),
            .rom_readdata   (rom_readdata)
        );

        // ROM slave: address presented in cycle n, data on rom_readdata in cycle n+LAT
        always @(posedge clk) begin
            rd_pipe[0] <= rom_fn(rom_address);
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign rom_readdata = rd_pipe[LAT-1];

        assign o_ready[g]     = bus.req_ready;
        assign o_rsp_valid[g] = bus.rsp_valid;
        assign o_rsp_data[g]  = bus.rsp_data;
        assign o_ack[g]       = pause_ack;
        assign o_cs[g]        = rom_chipselect;
        assign o_clken[g]     = rom_clken;
        assign o_wr[g]        = rom_write;
        assign o_dbg[g]       = rom_debugaccess;
        assign o_addr[g]      = rom_address;
        assign o_wdata[g]     = rom_writedata;
        assign o_be[g]        = rom_byteenable;
    end

    // Reference model: grant from the arbitration rule, pause from the handshake rules.
    int  ptr_m = NR - 1;
    bit  run_m = 1'b1;
    bit  paused_m [2];
    bit  rst_prev_model = 1'b0;
    int  acc_hist [$];

    function automatic int exp_grant(logic [NR-1:0] v, int p);
`ifdef ROM_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NR; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NR; k++) if (v[(p + k) % NR]) return (p + k) % NR;
`endif
        return -1;
    endfunction

    function automatic int inflight(int lat, int now);
        int c = 0;
        foreach (acc_hist[i]) if (acc_hist[i] >= now - lat && acc_hist[i] <= now - 1) c++;
        return c;
    endfunction

    always @(negedge clk) begin
        int            g_exp;
        logic [NR-1:0] rdy_exp;
        logic [AW-1:0] a_exp;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_ready%0d", k), o_ready[k], 0);
                chk($sformatf("rst_cs%0d", k), o_cs[k], 0);
                chk($sformatf("rst_clken%0d", k), o_clken[k], 0);
                chk($sformatf("rst_addr%0d", k), o_addr[k], 0);
                if (rst_prev_model) chk($sformatf("rst_ack%0d", k), o_ack[k], 0);
            end
            ptr_m = NR - 1;
            run_m = 1'b1;
            paused_m = '{1'b0, 1'b0};
            acc_hist.delete();
        end else begin
            g_exp   = (run_m && !pause_req) ? exp_grant(req_valid, ptr_m) : -1;
            rdy_exp = (g_exp >= 0) ? NR'(1) << g_exp : '0;
            a_exp   = (g_exp >= 0) ? req_addr[g_exp*AW +: AW] : '0;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready%0d", k), o_ready[k], rdy_exp);
                chk($sformatf("pause_ack%0d", k), o_ack[k], paused_m[k]);
                chk($sformatf("chipselect%0d", k), o_cs[k], g_exp >= 0);
                chk($sformatf("rom_address%0d", k), o_addr[k], a_exp);
                chk($sformatf("rom_consts%0d", k),
                    {o_clken[k], o_wr[k], o_dbg[k], o_wdata[k], o_be[k]},
                    {1'b1, 1'b0, 1'b0, {DW{1'b0}}, {(DW/8){1'b1}}});
                if (g_exp >= 0) sb[k].push_back('{id: g_exp, data: rom_fn(a_exp), due: cyc + k + 2});
            end
            if (g_exp >= 0) begin
                ptr_m = g_exp;
                acc_hist.push_back(cyc);
            end
            if (run_m) begin
                if (pause_req) begin
                    run_m = 1'b0;
                    paused_m = '{1'b0, 1'b0};
                end
            end else if (!pause_req) begin
                run_m = 1'b1;
                paused_m = '{1'b0, 1'b0};
            end else begin
                for (int k = 0; k < 2; k++) if (inflight(k + 1, cyc) == 0) paused_m[k] = 1'b1;
            end
            while (acc_hist.size() > 0 && acc_hist[0] < cyc - 4) void'(acc_hist.pop_front());
        end
        rst_prev_model = rst;
    end

    // Monitor: pops the expected response whenever a DUT presents rsp_valid.
    bit rst_prev_mon = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst_prev_mon) begin
                chk($sformatf("rst_rsp_valid%0d", k), o_rsp_valid[k], 0);
                chk($sformatf("rst_rsp_data%0d", k), o_rsp_data[k], 0);
            end else begin
                while (sb[k].size() > 0 && sb[k][0].due < cyc) begin
                    e = sb[k].pop_front();
                    chk($sformatf("rsp_missing%0d", k), cyc, e.due);
                end
                if (o_rsp_valid[k] != '0) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("rsp_unexpected%0d", k), o_rsp_valid[k], 0);
                    end else if (sb[k][0].due != cyc) begin
                        chk($sformatf("rsp_early%0d", k), cyc, sb[k][0].due);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("rsp_id%0d", k), o_rsp_valid[k], NR'(1) << e.id);
                        chk($sformatf("rsp_data%0d", k), o_rsp_data[k], e.data);
                    end
                end
            end
            if (rst) sb[k].delete();
        end
        rst_prev_mon = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_addr();
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = AW'($urandom);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        req_valid = '1;
        req_addr = '0;
        pause_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("first_grant%0d", k), o_ready[k], 3'b001);
        step();
        req_valid = '0;
        step();

        // single read of address 5 by requester 0
        req_valid = 3'b001;
        req_addr[0 +: AW] = 10'h005;
        step();
        req_valid = '0;
        repeat (4) step();

        // contention from a fresh reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        req_valid = 3'b011;
        for (int i = 0; i < 6; i++) begin
            rand_addr();
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                chk($sformatf("contention%0d_%0d", k, i), o_ready[k], (i % 2) ? 3'b010 : 3'b001);
            step();
        end

        // pause with reads in flight
        req_valid = 3'b111;
        rand_addr();
        step();
        rand_addr();
        step();
        pause_req = 1'b1;
        @(negedge clk);
        chk("pause_ready_now", o_ready, 0);
        step();
        w = 0;
        while (o_ack != 2'b11 && w < 20) begin
            step();
            w++;
        end
        chk("pause_ack_reached", w < 20, 1);
        pause_req = 1'b0;
        @(negedge clk);
        chk("paused_ready", o_ready, 0);
        step();
        @(negedge clk);
        chk("resume_grant", o_ready[1] != '0, 1);
        step();

        // randomized traffic with occasional pause toggles and resets
        for (int i = 0; i < 400; i++) begin
            req_valid = NR'($urandom);
            rand_addr();
            if ($urandom_range(0, 19) == 0) pause_req = ~pause_req;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        pause_req = 1'b0;
        req_valid = '0;
        repeat (4) step();

        // reset right after an accept
        req_valid = 3'b001;
        rand_addr();
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();

`ifdef ROM_ARB_FIXED_PRIO_EN
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk($sformatf("fixed_prio%0d_%0d", k, i), o_ready[k], 3'b001);
            step();
        end
        req_valid = '0;
`endif

        repeat (6) step();
        for (int k = 0; k < 2; k++) chk($sformatf("drained%0d", k), sb[k].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
